// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding, default parameters and word/address types
package mem_resp_pkg;
   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DEPTH = 1024;
   localparam int DEF_READ_LATENCY = 2;
   typedef logic [DEF_DATA_W-1:0] word_t;
   typedef logic [DEF_ADDR_W-1:0] addr_t;
   localparam word_t DEF_CLR_VALUE = '0;
endpackage

// File: rtl/mem_resp_rd_pipe.sv
// mem_resp_rd_pipe: LAT-deep {valid,data} shift; output register loads only on valid
module mem_resp_rd_pipe
   import mem_resp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LAT = DEF_READ_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              v_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);
   logic last_v;
   logic [DATA_W-1:0] last_d, q_q;
   if (LAT == 1) begin : g_direct
      assign last_v = v_i;
      assign last_d = d_i;
   end else begin : g_pipe
      logic [LAT-2:0] v_q;
      logic [DATA_W-1:0] d_q [LAT-1];
      always_ff @(posedge clk or posedge rst)
         if (rst) v_q <= '0;
         else begin
            v_q[0] <= v_i;
            for (int i = 1; i < LAT-1; i++) v_q[i] <= v_q[i-1];
         end
      always_ff @(posedge clk) begin
         d_q[0] <= d_i;
         for (int i = 1; i < LAT-1; i++) d_q[i] <= d_q[i-1];
      end
      assign last_v = v_q[LAT-2];
      assign last_d = d_q[LAT-2];
   end
   // holds the last completed read through idle cycles
   always_ff @(posedge clk or posedge rst)
      if (rst) q_q <= '0;
      else if (last_v) q_q <= last_d;
   assign q_o = q_q;
endmodule

// File: rtl/ap_mem_responder.sv
// ap_mem_responder: ap-style single-port word memory with bulk clear and sticky error flag.
// Define MEM_RESP_STATS_EN to build saturating read/write counters.
module ap_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY,
   parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [31:0]       mem_address0,
   input  logic              mem_ce0,
   input  logic              mem_we0,
   input  logic [DATA_W-1:0] mem_d0,
   output logic [DATA_W-1:0] mem_q0,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              err,
   input  logic              err_clr,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count
);
   state_e state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic done_q, err_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic busy, oor, acc, rd_ok, wr_ok, last;
   logic [ADDR_W-1:0] a;
   assign busy = state_q == ST_CLEAR;
   assign oor = mem_address0 >= 32'(DEPTH);
   assign acc = mem_ce0 && !busy;
   assign rd_ok = acc && !mem_we0 && !oor;
   assign wr_ok = acc && mem_we0 && !oor;
   assign a = mem_address0[ADDR_W-1:0];
   assign last = busy && cnt_q == (ADDR_W+1)'(DEPTH-1);
   always_comb begin
      state_d = busy ? (last ? ST_IDLE : ST_CLEAR) : (clr_start ? ST_CLEAR : ST_IDLE);
      cnt_d = busy ? cnt_q + (ADDR_W+1)'(1) : '0;
   end
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         done_q <= last;
         err_q <= (mem_ce0 && (busy || oor)) || (err_q && !err_clr);
      end
   // the clear engine owns the write port while busy
   always_ff @(posedge ap_clk)
      if (busy) mem[cnt_q[ADDR_W-1:0]] <= CLR_VALUE;
      else if (wr_ok) mem[a] <= mem_d0;
   mem_resp_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd_pipe (
      .clk(ap_clk),
      .rst(ap_rst),
      .v_i(acc && !mem_we0),
      .d_i(oor ? '0 : mem[a]),
      .q_o(mem_q0)
   );
   assign clr_busy = busy;
   assign clr_done = done_q;
   assign err = err_q;
`ifdef MEM_RESP_STATS_EN
   logic [31:0] rd_q, wr_q;
   logic clr_acc;
   assign clr_acc = !busy && clr_start;
   always_ff @(posedge ap_clk or posedge ap_rst)
      if (ap_rst) begin
         rd_q <= '0;
         wr_q <= '0;
      end else begin
         rd_q <= clr_acc ? '0 : (rd_ok && ~&rd_q) ? rd_q + 32'd1 : rd_q;
         wr_q <= clr_acc ? '0 : (wr_ok && ~&wr_q) ? wr_q + 32'd1 : wr_q;
      end
   assign rd_count = rd_q;
   assign wr_count = wr_q;
`else
   assign rd_count = '0;
   assign wr_count = '0;
`endif
endmodule

// File: tb/tb_ap_mem_responder.sv
// tb_ap_mem_responder: directed bench with a read-result scoreboard for ap_mem_responder
module tb_ap_mem_responder;
   localparam int LAT = 2;
   localparam int DEPTH = 1024;
   localparam logic [31:0] CLR = 32'h0;
`ifdef MEM_RESP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   typedef struct {int due; logic [31:0] val;} exp_t;
   logic ap_clk = 0, ap_rst = 1, ce = 0, we = 0, clr_start = 0, err_clr = 0;
   logic [31:0] addr = 0, d = 0, q, rd_count, wr_count;
   logic clr_busy, clr_done, err;
   logic [31:0] model [DEPTH];
   logic [31:0] last_q = 0;
   exp_t sb[$];
   exp_t e;
   int cyc = 0, n_cmp = 0, n_err = 0, n_rd = 0, n_wr = 0, busy_n, done_n;

   ap_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(DEPTH), .READ_LATENCY(LAT), .CLR_VALUE(CLR)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .mem_address0(addr), .mem_ce0(ce), .mem_we0(we),
      .mem_d0(d), .mem_q0(q), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .err(err), .err_clr(err_clr), .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge ap_clk)
      if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk("rd_data", q, e.val);
         last_q = e.val;
      end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge ap_clk);
         ce = 0; we = 0; err_clr = 0; clr_start = 0;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      @(negedge ap_clk);
      ce = 1; we = 1; addr = a; d = v;
      if (a < DEPTH) begin
         model[a] = v;
         n_wr++;
      end
   endtask

   task automatic rd(input logic [31:0] a);
      @(negedge ap_clk);
      ce = 1; we = 0; addr = a;
      sb.push_back('{cyc + LAT, (a < DEPTH) ? model[a] : 32'h0});
      if (a < DEPTH) n_rd++;
   endtask

   task automatic drain();
      int n = 0;
      idle(1);
      while (sb.size() > 0 && n < 20) begin
         idle(1);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'h0);
      sb.delete();
      idle(1);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_rd_count"}, rd_count, STATS ? 32'(n_rd) : 32'h0);
      chk({tag, "_wr_count"}, wr_count, STATS ? 32'(n_wr) : 32'h0);
   endtask

   task automatic run_clear(input int rd_at);
      @(negedge ap_clk);
      clr_start = 1; ce = 0;
      n_rd = 0; n_wr = 0;
      busy_n = 0; done_n = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge ap_clk);
         clr_start = 0; we = 0; addr = 3;
         ce = (i == rd_at);
         busy_n += int'(clr_busy);
         done_n += int'(clr_done);
         if (rd_at >= 0 && i == rd_at + 2) begin
            chk("busy_err", {31'h0, err}, 32'h1);
            chk("busy_q_hold", q, last_q);
         end
         if (done_n > 0 && !clr_busy) break;
      end
      ce = 0;
      chk("clr_busy_cycles", 32'(busy_n), 32'(DEPTH));
      chk("clr_done_pulses", 32'(done_n), 32'h1);
      for (int i = 0; i < DEPTH; i++) model[i] = CLR;
   endtask

   task automatic clear_err();
      @(negedge ap_clk);
      ce = 0; err_clr = 1;
      @(negedge ap_clk);
      err_clr = 0;
      chk("err_cleared", {31'h0, err}, 32'h0);
   endtask

   initial begin
      idle(2);
      chk("rst_q", q, 32'h0);
      chk("rst_busy", {31'h0, clr_busy}, 32'h0);
      chk("rst_done", {31'h0, clr_done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk_counts("rst");
      ap_rst = 0;
      wr(0, 32'h11); wr(1, 32'h22); wr(2, 32'h33);
      rd(0); rd(1); rd(2);
      wr(5, 32'h55); wr(7, 32'h77); wr(3, 32'h3333);
      wr(9, 32'hA5A5); rd(9);
      rd(5);
      drain();
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("hold", q, 32'h55);
      end
      @(negedge ap_clk);
      ce = 0; we = 1; addr = 0; d = 32'hBAD;
      rd(0);
      drain();
      chk("no_err_yet", {31'h0, err}, 32'h0);
      wr(1024, 32'hDEAD);
      idle(1);
      chk("oor_wr_err", {31'h0, err}, 32'h1);
      rd(1024);
      rd(0);
      rd(32'h8000_0000);
      rd(1);
      drain();
      clear_err();
      @(negedge ap_clk);
      ce = 1; we = 0; addr = 2000; err_clr = 1;
      sb.push_back('{cyc + LAT, 32'h0});
      idle(1);
      chk("set_wins", {31'h0, err}, 32'h1);
      drain();
      clear_err();
      chk_counts("pre_clear");
      run_clear(10);
      chk_counts("post_clear");
      clear_err();
      rd(7); rd(1023);
      drain();
      wr(3, 32'h33); rd(3);
      drain();
      wr(2048, 32'h1);
      idle(1);
      @(negedge ap_clk);
      clr_start = 1;
      idle(100);
      chk("mid_busy", {31'h0, clr_busy}, 32'h1);
      ap_rst = 1;
      #1;
      chk("async_busy", {31'h0, clr_busy}, 32'h0);
      chk("async_q", q, 32'h0);
      chk("async_err", {31'h0, err}, 32'h0);
      last_q = 0; n_rd = 0; n_wr = 0;
      chk_counts("async");
      @(negedge ap_clk);
      ap_rst = 0;
      run_clear(-1);
      wr(10, 32'h1); wr(11, 32'h2); wr(12, 32'h3);
      rd(10); rd(11); rd(12); rd(0); rd(10); rd(4000);
      drain();
      chk_counts("stats");
      @(negedge ap_clk);
      clr_start = 1;
      n_rd = 0; n_wr = 0;
      idle(1);
      chk_counts("stats_clr");
      for (int i = 0; i < 1100 && clr_busy; i++) idle(1);
      chk("final_idle", {31'h0, clr_busy}, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
